// File: rtl/digit_scroll_matrix_if.sv
`default_nettype none
// ============================================================================
// Module   : digit_scroll_matrix_if
// Brief    : Key-event input and LED-matrix output bundle of the digit scroller.
// Revision : 1.0
// ============================================================================
interface digit_scroll_matrix_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             key_valid;
  logic [3:0]       key_code;
  logic [7:0]       row;
  logic [7:0]       column_red;
  logic             busy;
  logic             overflow;
  logic [CNT_W-1:0] fifo_count;

  modport master (
    output key_valid, key_code,
    input  row, column_red, busy, overflow, fifo_count
  );

  modport slave (
    input  key_valid, key_code,
    output row, column_red, busy, overflow, fifo_count
  );
endinterface
`default_nettype wire

// File: rtl/digit_scroll_matrix.sv
`default_nettype none
// ============================================================================
// Module   : digit_scroll_matrix
// Brief    : Queues keypad digits and scrolls each onto the 8x8 LED matrix.
// Revision : 1.0
// ============================================================================
module digit_scroll_matrix #(
  parameter int SCAN_DIV    = 8192,
  parameter int STEP_FRAMES = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  wire logic            clk_in,
  input  wire logic            reset,
  digit_scroll_matrix_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int FRM_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;

  localparam logic [3:0]       c_blank    = 4'hF;
  localparam logic [CNT_W-1:0] c_full     = CNT_W'(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(SCAN_DIV - 1);
  localparam logic [FRM_W-1:0] c_frm_last = FRM_W'(STEP_FRAMES - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_idx;
  logic [FRM_W-1:0] r_frame;
  logic [3:0]       r_cur, r_nxt;
  logic [2:0]       r_off;
  logic [7:0]       r_row, r_col;
  logic             r_ovf;
  logic [3:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr, r_rd;
  logic [CNT_W-1:0] r_count;

  logic       w_tick, w_step, w_pop, w_adv, w_done;
  logic       w_digit, w_full, w_push, w_drop;
  logic [2:0] w_idx_nxt;
  logic [3:0] w_shamt;
  logic [7:0] w_cur_row, w_nxt_row, w_col;

  // Codes above 9 (including the blank marker) render as an empty glyph.
  function automatic logic [7:0] font_row(input logic [3:0] d, input logic [2:0] r);
    logic [63:0] g;
    case (d)
      4'd0:    g = 64'h3C42_464A_5262_3C00;
      4'd1:    g = 64'h0818_0808_0808_1C00;
      4'd2:    g = 64'h3C42_4204_0810_7E00;
      4'd3:    g = 64'h3C42_023C_0242_3C00;
      4'd4:    g = 64'h1C24_4444_447E_0400;
      4'd5:    g = 64'h7E40_407C_0242_3C00;
      4'd6:    g = 64'h4040_407E_4242_7E00;
      4'd7:    g = 64'h7E42_4202_0202_0200;
      4'd8:    g = 64'h3C42_427E_4242_3C00;
      4'd9:    g = 64'h3C42_423E_0202_3C00;
      default: g = 64'h0;
    endcase
    return g[{~r, 3'b000} +: 8];
  endfunction

  assign w_tick    = (r_div == c_div_last);
  assign w_step    = w_tick && (r_idx == 3'd7) && (r_frame == c_frm_last);
  assign w_idx_nxt = r_idx + 3'd1;

  // Shift amount kept in 4 bits so offset 0 shifts the incoming glyph fully out.
  assign w_shamt   = 4'd8 - {1'b0, r_off};
  assign w_cur_row = font_row(r_cur, w_idx_nxt);
  assign w_nxt_row = font_row(r_nxt, w_idx_nxt);
  assign w_col     = (w_cur_row << r_off) | (w_nxt_row >> w_shamt);

  assign w_digit = bus.key_valid && (bus.key_code <= 4'd9);
  assign w_full  = (r_count == c_full);
  assign w_push  = w_digit && (!w_full || w_pop);
  assign w_drop  = w_digit && w_full && !w_pop;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_adv       = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_step) begin
          if (r_off == 3'd7) begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_adv = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_div   <= '0;
      r_idx   <= 3'd0;
      r_frame <= '0;
      r_row   <= 8'h80;
      r_col   <= 8'h00;
      r_cur   <= c_blank;
      r_nxt   <= c_blank;
      r_off   <= 3'd0;
      r_ovf   <= 1'b0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick) begin
        r_idx <= w_idx_nxt;
        r_row <= 8'h80 >> w_idx_nxt;
        r_col <= w_col;
        if (r_idx == 3'd7)
          r_frame <= (r_frame == c_frm_last) ? '0 : r_frame + 1'b1;
      end

      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_drop) r_ovf <= 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase

      if (w_pop) begin
        r_nxt <= r_mem[r_rd];
        r_rd  <= r_rd + 1'b1;
        r_off <= 3'd0;
      end else if (w_adv) begin
        r_off <= r_off + 3'd1;
      end else if (w_done) begin
        r_cur <= r_nxt;
        r_off <= 3'd0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_push) r_mem[r_wr] <= bus.key_code;
  end

  assign bus.row        = r_row;
  assign bus.column_red = r_col;
  assign bus.busy       = (r_state == S_SHIFT) || (r_count != '0);
  assign bus.overflow   = r_ovf;
  assign bus.fifo_count = r_count;
endmodule
`default_nettype wire

// File: tb/tb_digit_scroll_matrix.sv
`default_nettype none
// ============================================================================
// Module   : tb_digit_scroll_matrix
// Brief    : Directed stimulus with a queue-based display model for digit_scroll_matrix.
// Revision : 1.0
// ============================================================================
module tb_digit_scroll_matrix;
  localparam int SCAN_DIV    = 2;
  localparam int STEP_FRAMES = 2;
  localparam int FIFO_DEPTH  = 4;
  localparam logic [63:0] GLYPH [10] = '{
    64'h3C42_464A_5262_3C00, 64'h0818_0808_0808_1C00, 64'h3C42_4204_0810_7E00,
    64'h3C42_023C_0242_3C00, 64'h1C24_4444_447E_0400, 64'h7E40_407C_0242_3C00,
    64'h4040_407E_4242_7E00, 64'h7E42_4202_0202_0200, 64'h3C42_427E_4242_3C00,
    64'h3C42_423E_0202_3C00};

  logic clk_in = 1'b0;
  logic reset  = 1'b0;
  int   n_vec  = 0;
  int   n_err  = 0;

  digit_scroll_matrix_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

  digit_scroll_matrix #(
    .SCAN_DIV(SCAN_DIV), .STEP_FRAMES(STEP_FRAMES), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_in(clk_in),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk_in = ~clk_in;

  // Display model: cycle and tick counts, a digit queue, and the glyph pair in view.
  int         m_t, m_ticks, m_off, m_cur, m_nxt;
  bit         m_shift, m_ovf;
  logic [7:0] m_row, m_col;
  int         m_q[$];

  function automatic logic [7:0] glyph_row(input int d, input int r);
    logic [63:0] g;
    if (d < 0 || d > 9) return 8'h00;
    g = GLYPH[d];
    return 8'((g >> (8 * (7 - r))) & 64'hFF);
  endfunction

  always @(posedge clk_in or posedge reset) begin : model
    int t_r, t_tk, t_size;
    bit t_tick, t_step, t_pop, t_dig;
    logic [15:0] t_w;
    if (reset) begin
      m_t <= 0; m_ticks <= 0; m_off <= 0; m_cur <= -1; m_nxt <= -1;
      m_shift <= 1'b0; m_ovf <= 1'b0; m_row <= 8'h80; m_col <= 8'h00;
      m_q.delete();
    end else begin
      t_tick = ((m_t + 1) % SCAN_DIV) == 0;
      t_step = 1'b0;
      m_t <= m_t + 1;
      if (t_tick) begin
        t_tk    = m_ticks + 1;
        t_r     = t_tk % 8;
        t_step  = (t_tk % (8 * STEP_FRAMES)) == 0;
        t_w     = {glyph_row(m_cur, t_r), glyph_row(m_nxt, t_r)} << m_off;
        m_ticks <= t_tk;
        m_row   <= 8'(1 << (7 - t_r));
        m_col   <= t_w[15:8];
      end
      t_size = m_q.size();
      t_pop  = !m_shift && t_size != 0;
      t_dig  = bus.key_valid && bus.key_code <= 4'd9;
      if (t_pop) begin
        m_nxt   <= m_q.pop_front();
        m_shift <= 1'b1;
        m_off   <= 0;
      end else if (m_shift && t_step) begin
        if (m_off == 7) begin
          m_cur   <= m_nxt;
          m_off   <= 0;
          m_shift <= 1'b0;
        end else begin
          m_off <= m_off + 1;
        end
      end
      if (t_dig && (t_size < FIFO_DEPTH || t_pop)) m_q.push_back(int'(bus.key_code));
      else if (t_dig) m_ovf <= 1'b1;
    end
  end

  always @(negedge clk_in) begin
    if (!reset) begin
      n_vec++;
      if (bus.row !== m_row || bus.column_red !== m_col ||
          bus.busy !== 1'(m_shift || m_q.size() != 0) || bus.overflow !== m_ovf ||
          int'(bus.fifo_count) != m_q.size()) begin
        n_err++;
        $display("FAIL model t=%0t: row %h/%h col %h/%h busy %b ovf %b/%b cnt %0d/%0d (dut/model)",
                 $time, bus.row, m_row, bus.column_red, m_col, bus.busy, bus.overflow, m_ovf,
                 bus.fifo_count, m_q.size());
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  logic [7:0] seq[$];
  logic [7:0] exp_seq [9];

  task automatic push(input logic [3:0] d);
    @(negedge clk_in); bus.key_valid = 1'b1; bus.key_code = d;
    @(negedge clk_in); bus.key_valid = 1'b0;
  endtask

  // Collects de-duplicated row-0 column data until two idle frames are seen.
  task automatic record_row0(input string name, input int budget);
    logic [7:0] prev;
    int n, idle;
    seq.delete();
    prev = bus.row; n = 0; idle = 0;
    while (idle < 2 && n < budget) begin
      @(negedge clk_in); n++;
      if (bus.row == 8'h80 && prev != 8'h80) begin
        if (seq.size() == 0 || seq[seq.size()-1] != bus.column_red) seq.push_back(bus.column_red);
        if (!bus.busy) idle++;
      end
      prev = bus.row;
    end
    check({name, "_done"}, int'(idle >= 2), 1);
  endtask

  task automatic check_seq(input string name, input int len);
    check({name, "_len"}, seq.size(), len);
    for (int i = 0; i < len && i < seq.size(); i++)
      check($sformatf("%s_%0d", name, i), seq[i], exp_seq[i]);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int n;
    bus.key_valid = 1'b0; bus.key_code = 4'd0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk_in);
    reset = 1'b0;
    check("rst_row", bus.row, 8'h80);
    check("rst_col", bus.column_red, 8'h00);
    check("rst_cnt", bus.fifo_count, 0);
    check("rst_busy", bus.busy, 0);

    push(4'd1);
    check("one_cnt_push", bus.fifo_count, 1);
    @(negedge clk_in);
    check("one_cnt_pop", bus.fifo_count, 0);
    check("one_busy", bus.busy, 1);
    record_row0("one", 800);
    exp_seq = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00};
    check_seq("one_row0", 5);
    n = 0;
    while (bus.row != 8'h40 && n < 40) begin @(negedge clk_in); n++; end
    check("one_row1", bus.column_red, 8'h18);
    check("one_idle", bus.busy, 0);

    push(4'd0);
    record_row0("zero", 800);
    push(4'd8);
    record_row0("eight", 800);
    exp_seq = '{8'h3C, 8'h78, 8'hF0, 8'hE1, 8'hC3, 8'h87, 8'h0F, 8'h1E, 8'h3C};
    check_seq("z2e_row0", 9);

    push(4'hA);
    check("inv_cnt", bus.fifo_count, 0);
    @(negedge clk_in);
    check("inv_busy", bus.busy, 0);

    for (int d = 2; d <= 7; d++) begin
      @(negedge clk_in); bus.key_valid = 1'b1; bus.key_code = 4'(d);
    end
    @(negedge clk_in); bus.key_valid = 1'b0;
    check("ovf_cnt", bus.fifo_count, 4);
    check("ovf_flag", bus.overflow, 1);
    record_row0("ovf", 3000);
    check("ovf_last_row0", (seq.size() > 0) ? int'(seq[seq.size()-1]) : -1, 8'h40);
    check("ovf_sticky", bus.overflow, 1);

    push(4'd9);
    n = 0;
    while (!(m_shift && m_off == 3) && n < 800) begin @(negedge clk_in); n++; end
    check("mid_reach", int'(n < 800), 1);
    @(posedge clk_in); #3 reset = 1'b1;
    #1;
    check("arst_row", bus.row, 8'h80);
    check("arst_col", bus.column_red, 8'h00);
    check("arst_cnt", bus.fifo_count, 0);
    check("arst_ovf", bus.overflow, 0);
    check("arst_busy", bus.busy, 0);
    @(negedge clk_in); @(negedge clk_in);
    reset = 1'b0;
    repeat (21) @(negedge clk_in);
    check("blank_col", bus.column_red, 8'h00);

    push(4'd5);
    record_row0("five", 800);
    exp_seq = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7E, 8'h00};
    check_seq("five_row0", 8);

    foreach (exp_seq[i]) exp_seq[i] = 8'h00;
    for (int d = 1; d <= 5; d++) begin
      @(negedge clk_in); bus.key_valid = 1'b1; bus.key_code = 4'(d % 5);
    end
    @(negedge clk_in); bus.key_valid = 1'b0;
    check("full_cnt", bus.fifo_count, 4);
    check("full_noovf", bus.overflow, 0);
    n = 0;
    while (!(!m_shift && m_q.size() == 4) && n < 800) begin @(negedge clk_in); n++; end
    check("full_reach", int'(n < 800), 1);
    bus.key_valid = 1'b1; bus.key_code = 4'd9;
    @(negedge clk_in); bus.key_valid = 1'b0;
    check("popush_cnt", bus.fifo_count, 4);
    check("popush_ovf", bus.overflow, 0);
    check("popush_busy", bus.busy, 1);
    repeat (40) @(negedge clk_in);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
